// File: rtl/cp0_pkg.sv
// Shared CP0 definitions: register numbers, exception codes and SR/Cause field positions.
package cp0_pkg;

  localparam logic [4:0] CP0_SR    = 5'd12;
  localparam logic [4:0] CP0_CAUSE = 5'd13;
  localparam logic [4:0] CP0_EPC   = 5'd14;
  localparam logic [4:0] CP0_PRID  = 5'd15;

  localparam logic [4:0] EXC_INT  = 5'd0;
  localparam logic [4:0] EXC_ADEL = 5'd4;
  localparam logic [4:0] EXC_ADES = 5'd5;
  localparam logic [4:0] EXC_RI   = 5'd10;
  localparam logic [4:0] EXC_OV   = 5'd12;

  localparam int SR_IE     = 0;
  localparam int SR_EXL    = 1;
  localparam int SR_IM_LO  = 10;
  localparam int SR_IM_HI  = 15;
  localparam int CAUSE_EXC_LO = 2;
  localparam int CAUSE_EXC_HI = 6;
  localparam int CAUSE_IP_LO  = 10;
  localparam int CAUSE_IP_HI  = 15;
  localparam int CAUSE_BD     = 31;

  // Only IM, EXL and IE exist in SR; everything else reads back as zero.
  localparam logic [31:0] SR_WMASK = 32'h0000_FC03;

endpackage

// File: rtl/cp0.sv
// Coprocessor-0 exception/interrupt controller holding SR, Cause, EPC and PRId.
// Optional macro CP0_EPC_BYPASS_EN forwards an in-flight mtc0 EPC write to epc_out.
module cp0
  import cp0_pkg::*;
#(
  parameter logic [31:0] PRID       = 32'h4255_4141,
  parameter logic [31:0] HANDLER_PC = 32'h0000_4180
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] pc_m,
  input  logic [5:0]  exc_m,
  input  logic        bd_m,
  input  logic [5:0]  hw_int,
  input  logic        we,
  input  logic [4:0]  addr,
  input  logic [31:0] din,
  input  logic        eret_m,
  output logic [31:0] dout,
  output logic        req,
  output logic [31:0] epc_out,
  output logic [31:0] handler_pc
);

  logic [31:0] sr_q, sr_d;
  logic [31:0] cause_q, cause_d;
  logic [31:0] epc_q, epc_d;
  logic        intReq, excReq;
  logic [31:0] trapPc;

  always_comb begin
    intReq = (|(hw_int & sr_q[SR_IM_HI:SR_IM_LO])) & sr_q[SR_IE] & ~sr_q[SR_EXL];
    excReq = exc_m[5] & ~sr_q[SR_EXL];
    req    = intReq | excReq;
    trapPc = bd_m ? (pc_m - 32'd4) : pc_m;
  end

  // A trap overrides both mtc0 and eret in the same cycle; IP always tracks the lines.
  always_comb begin
    sr_d    = sr_q;
    cause_d = cause_q;
    epc_d   = epc_q;
    cause_d[CAUSE_IP_HI:CAUSE_IP_LO] = hw_int;
    if (req) begin
      sr_d[SR_EXL] = 1'b1;
      cause_d[CAUSE_EXC_HI:CAUSE_EXC_LO] = intReq ? EXC_INT : exc_m[4:0];
      cause_d[CAUSE_BD] = bd_m;
      epc_d = {trapPc[31:2], 2'b00};
    end else begin
      if (we && addr == CP0_SR)  sr_d  = din & SR_WMASK;
      if (we && addr == CP0_EPC) epc_d = din;
      if (eret_m)                sr_d[SR_EXL] = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      sr_q    <= '0;
      cause_q <= '0;
      epc_q   <= '0;
    end else begin
      sr_q    <= sr_d;
      cause_q <= cause_d;
      epc_q   <= epc_d;
    end
  end

  always_comb begin
    case (addr)
      CP0_SR:    dout = sr_q;
      CP0_CAUSE: dout = cause_q;
      CP0_EPC:   dout = epc_q;
      CP0_PRID:  dout = PRID;
      default:   dout = 32'd0;
    endcase
  end

`ifdef CP0_EPC_BYPASS_EN
  assign epc_out = (we && addr == CP0_EPC) ? din : epc_q;
`else
  assign epc_out = epc_q;
`endif

  assign handler_pc = HANDLER_PC;

endmodule

// File: tb/tb_cp0.sv
// Randomised bench for cp0 against a field-level behavioural model, plus directed literal checks.
module tb_cp0;

  localparam logic [31:0] PRID_C    = 32'h4255_4141;
  localparam logic [31:0] HANDLER_C = 32'h0000_4180;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [31:0] pc_m = '0;
  logic [5:0]  exc_m = '0;
  logic        bd_m = 1'b0;
  logic [5:0]  hw_int = '0;
  logic        we = 1'b0;
  logic [4:0]  addr = '0;
  logic [31:0] din = '0;
  logic        eret_m = 1'b0;
  logic [31:0] dout;
  logic        req;
  logic [31:0] epc_out;
  logic [31:0] handler_pc;

  int checks = 0;
  int errors = 0;
  bit checkEn = 1'b0;

  cp0 #(.PRID(PRID_C), .HANDLER_PC(HANDLER_C)) dut (
    .clk(clk), .reset(reset), .pc_m(pc_m), .exc_m(exc_m), .bd_m(bd_m),
    .hw_int(hw_int), .we(we), .addr(addr), .din(din), .eret_m(eret_m),
    .dout(dout), .req(req), .epc_out(epc_out), .handler_pc(handler_pc)
  );

  always #5 clk = ~clk;

  // Architectural state as named fields rather than packed registers.
  typedef struct {
    logic [5:0]  im;
    logic        exl;
    logic        ie;
    logic        bd;
    logic [5:0]  ip;
    logic [4:0]  code;
    logic [31:0] epc;
  } mState_t;

  mState_t ms = '{im: 6'd0, exl: 1'b0, ie: 1'b0, bd: 1'b0, ip: 6'd0, code: 5'd0, epc: 32'd0};

  function automatic bit modelInt(mState_t s);
    return ((hw_int & s.im) != 6'd0) && s.ie && !s.exl;
  endfunction

  function automatic bit modelReq(mState_t s);
    return modelInt(s) || (exc_m[5] && !s.exl);
  endfunction

  function automatic mState_t modelStep(mState_t s);
    mState_t n;
    logic [31:0] t;
    n = s;
    if (reset) begin
      n = '{im: 6'd0, exl: 1'b0, ie: 1'b0, bd: 1'b0, ip: 6'd0, code: 5'd0, epc: 32'd0};
    end else begin
      n.ip = hw_int;
      if (modelReq(s)) begin
        n.exl  = 1'b1;
        n.code = modelInt(s) ? 5'd0 : exc_m[4:0];
        n.bd   = bd_m;
        t      = bd_m ? pc_m - 32'd4 : pc_m;
        n.epc  = (t / 4) * 4;
      end else begin
        if (we && addr == 5'd12) begin
          n.im  = din[15:10];
          n.exl = din[1];
          n.ie  = din[0];
        end
        if (we && addr == 5'd14) n.epc = din;
        if (eret_m) n.exl = 1'b0;
      end
    end
    return n;
  endfunction

  function automatic logic [31:0] modelDout(mState_t s);
    case (addr)
      5'd12:   return (32'(s.im) << 10) + (32'(s.exl) << 1) + 32'(s.ie);
      5'd13:   return (32'(s.bd) << 31) + (32'(s.ip) << 10) + (32'(s.code) << 2);
      5'd14:   return s.epc;
      5'd15:   return PRID_C;
      default: return 32'd0;
    endcase
  endfunction

  function automatic logic [31:0] modelEpcOut(mState_t s);
`ifdef CP0_EPC_BYPASS_EN
    if (we && addr == 5'd14) return din;
`endif
    return s.epc;
  endfunction

  always @(posedge clk) ms <= modelStep(ms);

  // Every cycle once reset has been seen, all outputs must match the model.
  always @(negedge clk) begin
    if (checkEn) begin
      checks += 4;
      if (req !== modelReq(ms)) begin
        errors++;
        $display("[TB] FAIL req: got %0b want %0b @%0t", req, modelReq(ms), $time);
      end
      if (dout !== modelDout(ms)) begin
        errors++;
        $display("[TB] FAIL dout addr=%0d: got %h want %h @%0t", addr, dout, modelDout(ms), $time);
      end
      if (epc_out !== modelEpcOut(ms)) begin
        errors++;
        $display("[TB] FAIL epc_out: got %h want %h @%0t", epc_out, modelEpcOut(ms), $time);
      end
      if (handler_pc !== HANDLER_C) begin
        errors++;
        $display("[TB] FAIL handler_pc: got %h want %h", handler_pc, HANDLER_C);
      end
    end
  end

  task automatic applyStimulus(input logic r, input logic w, input logic [4:0] a,
                               input logic [31:0] d, input logic [5:0] e,
                               input logic [31:0] pc, input logic b,
                               input logic [5:0] hw, input logic er);
    @(posedge clk);
    #1;
    reset = r; we = w; addr = a; din = d; exc_m = e; pc_m = pc; bd_m = b;
    hw_int = hw; eret_m = er;
    @(negedge clk);
  endtask

  task automatic checkOutput(input string name, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("[TB] FAIL %s: got %h want %h", name, got, want);
    end
  endtask

  task automatic readReg(input logic [4:0] a, input logic [5:0] hw);
    applyStimulus(1'b0, 1'b0, a, 32'd0, 6'd0, 32'd0, 1'b0, hw, 1'b0);
  endtask

  initial begin
    applyStimulus(1'b1, 1'b0, 5'd0, 32'd0, 6'd0, 32'd0, 1'b0, 6'd0, 1'b0);
    checkEn = 1'b1;

    readReg(5'd12, 6'd0); checkOutput("rst_sr", dout, 32'd0);
    checkOutput("rst_req", {31'd0, req}, 32'd0);
    readReg(5'd13, 6'd0); checkOutput("rst_cause", dout, 32'd0);
    readReg(5'd14, 6'd0); checkOutput("rst_epc", dout, 32'd0);
    checkOutput("rst_epc_out", epc_out, 32'd0);
    readReg(5'd15, 6'd0); checkOutput("rst_prid", dout, PRID_C);

    // Interrupt trap.
    applyStimulus(1'b0, 1'b1, 5'd12, 32'h0000_0401, 6'd0, 32'h2000, 1'b0, 6'd0, 1'b0);
    applyStimulus(1'b0, 1'b0, 5'd12, 32'd0, 6'd0, 32'h2000, 1'b0, 6'b000001, 1'b0);
    checkOutput("int_req", {31'd0, req}, 32'd1);
    readReg(5'd12, 6'b000001);
    checkOutput("int_sr", dout, 32'h0000_0403);
    checkOutput("int_req_after", {31'd0, req}, 32'd0);
    readReg(5'd13, 6'b000001); checkOutput("int_cause", dout, 32'h0000_0400);
    readReg(5'd14, 6'd0); checkOutput("int_epc", dout, 32'h2000);

    // Overflow in a delay slot.
    applyStimulus(1'b0, 1'b1, 5'd12, 32'd0, 6'd0, 32'd0, 1'b0, 6'd0, 1'b0);
    applyStimulus(1'b0, 1'b0, 5'd0, 32'd0, 6'b101100, 32'h3010, 1'b1, 6'd0, 1'b0);
    checkOutput("ov_req", {31'd0, req}, 32'd1);
    readReg(5'd14, 6'd0); checkOutput("ov_epc", dout, 32'h300C);
    readReg(5'd13, 6'd0); checkOutput("ov_cause", dout, 32'h8000_0030);

    // Nested exception lost while EXL=1, then eret.
    applyStimulus(1'b0, 1'b0, 5'd13, 32'd0, 6'b100100, 32'h3100, 1'b0, 6'd0, 1'b0);
    checkOutput("nest_req", {31'd0, req}, 32'd0);
    readReg(5'd13, 6'd0); checkOutput("nest_cause", dout, 32'h8000_0030);
    applyStimulus(1'b0, 1'b0, 5'd12, 32'd0, 6'd0, 32'd0, 1'b0, 6'd0, 1'b1);
    readReg(5'd12, 6'd0); checkOutput("eret_sr", dout, 32'd0);

    // mtc0 EPC suppressed by a simultaneous trap.
    applyStimulus(1'b0, 1'b1, 5'd14, 32'h5000, 6'b100101, 32'h6000, 1'b0, 6'd0, 1'b0);
    checkOutput("sup_req", {31'd0, req}, 32'd1);
    readReg(5'd14, 6'd0); checkOutput("sup_epc", dout, 32'h6000);
    applyStimulus(1'b0, 1'b1, 5'd14, 32'h5000, 6'd0, 32'd0, 1'b0, 6'd0, 1'b0);
`ifdef CP0_EPC_BYPASS_EN
    checkOutput("byp_epc_out", epc_out, 32'h5000);
`else
    checkOutput("nobyp_epc_out", epc_out, 32'h6000);
`endif
    readReg(5'd14, 6'd0); checkOutput("wr_epc", dout, 32'h5000);

    // Masked interrupt line still visible in IP.
    applyStimulus(1'b0, 1'b1, 5'd12, 32'h0000_0001, 6'd0, 32'd0, 1'b0, 6'd0, 1'b0);
    applyStimulus(1'b0, 1'b0, 5'd13, 32'd0, 6'd0, 32'd0, 1'b0, 6'b100000, 1'b0);
    checkOutput("mask_req", {31'd0, req}, 32'd0);
    readReg(5'd13, 6'b100000); checkOutput("mask_ip", dout, 32'h0000_8014);

    // Reset wins over a pending trap.
    applyStimulus(1'b0, 1'b0, 5'd0, 32'd0, 6'b101010, 32'h7000, 1'b0, 6'd0, 1'b0);
    applyStimulus(1'b0, 1'b1, 5'd12, 32'h0000_0001, 6'd0, 32'd0, 1'b0, 6'd0, 1'b1);
    applyStimulus(1'b1, 1'b0, 5'd0, 32'd0, 6'b101100, 32'h7100, 1'b0, 6'd0, 1'b0);
    checkOutput("rstreq_req", {31'd0, req}, 32'd1);
    readReg(5'd12, 6'd0); checkOutput("rstreq_sr", dout, 32'd0);
    readReg(5'd14, 6'd0); checkOutput("rstreq_epc", dout, 32'd0);

    // Randomised traffic; reset cycles keep the interrupt lines quiet.
    for (int i = 0; i < 600; i++) begin
      logic r, w, b, er;
      logic [4:0]  a;
      logic [5:0]  e, hw;
      r  = ($urandom_range(0, 63) == 0);
      w  = ($urandom_range(0, 3) == 0);
      er = ($urandom_range(0, 7) == 0);
      b  = 1'($urandom);
      a  = ($urandom_range(0, 4) == 0) ? 5'($urandom) : 5'($urandom_range(12, 15));
      e  = {($urandom_range(0, 3) == 0), 5'($urandom)};
      hw = ($urandom_range(0, 1) == 0) ? 6'd0 : 6'($urandom);
      if (r) hw = 6'd0;
      applyStimulus(r, w, a, $urandom, e, $urandom, b, hw, er);
    end

    checkEn = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/cp0.md
# cp0

Coprocessor-0 exception/interrupt controller: the consumer end of the `{valid, ExcCode}` exception bus produced by the execute stage and carried down the pipeline. Sits beside the M stage.
- Takes the M-stage exception code, PC and delay-slot flag together with the six hardware interrupt lines.
- Decides whether the pipeline must trap, and holds the architectural SR, Cause, EPC and PRId registers.
- Serves `mtc0`, `mfc0` and `eret`.

## Interface
Parameters:
- PRID, 32'h4255_4141, read-only processor ID value.
- HANDLER_PC, 32'h0000_4180, exception entry address driven on `handler_pc`.

Ports:
- clk  in  1  pipeline clock.
- reset  in  1  synchronous, active-high; one clock; acts on rising `clk`.
- pc_m  in  32  PC of the instruction in M.
- exc_m  in  6  `{valid, ExcCode[4:0]}`; `valid`=1 means the M instruction faulted (Ov=12, AdEL=4, AdES=5, RI=10).
- bd_m  in  1  M instruction is in a branch delay slot.
- hw_int  in  6  external interrupt lines, level-sensitive.
- we  in  1  `mtc0` write enable.
- addr  in  5  CP0 register number for `mtc0`/`mfc0`.
- din  in  32  `mtc0` write data.
- eret_m  in  1  `eret` is in M.
- dout  out  32  `mfc0` read data, combinational.
- req  out  1  trap request; flush F–M and redirect PC; combinational.
- epc_out  out  32  current EPC, for the `eret` target.
- handler_pc  out  32  constant HANDLER_PC.

## Operation
Register map:
- SR (12): IM[15:10], EXL[1], IE[0]; other bits read 0.
- Cause (13): BD[31], IP[15:10], ExcCode[6:2]; other bits read 0. Not writable by `mtc0`.
- EPC (14): 32-bit, writable.
- PRId (15): constant PRID.
- All other addresses read 0; writes to them are ignored.

Request logic:
- int_req = `|(hw_int & SR.IM) & SR.IE & ~SR.EXL`.
- exc_req = `exc_m[5] & ~SR.EXL`.
- req = int_req | exc_req. Interrupt takes priority over exception.

On a req edge:
- EXL←1.
- ExcCode←0 if int_req, else `exc_m[4:0]`.
- BD←`bd_m`.
- EPC←`bd_m ? pc_m-4 : pc_m`, with bits [1:0] forced to 0.

Every edge: IP←`hw_int`. This runs regardless of req, including during reset release.

`eret_m`: EXL←0 on the edge. When `eret_m` and req are asserted together, req wins: EXL stays 1 and EPC is reloaded.

`mtc0`:
- We=1 writes SR or EPC on the edge.
- Suppressed when req is asserted in the same cycle.
- A `mtc0` to SR and an `eret_m` in the same cycle: SR takes `din`, and then EXL is cleared.

Reset values:
- SR = 0, Cause = 0, EPC = 0.
- Outputs: `dout` = 0 for addresses 12–14 and PRID for address 15; `req` = 0; `epc_out` = 0.

Width rules:
- `pc_m-4` is 32-bit modular.
- ExcCode is stored unchanged, with no re-encoding.

## Timing
- `req`, `dout` and `epc_out` are combinational from the current register state and inputs; there are no input registers.
- Register updates land on the next rising edge, so `mfc0` in the cycle after `mtc0` reads the new value.
- While EXL=1, no further req is raised; nested exceptions are lost by design.
- `exc_m` with `valid`=0 never traps, even if the ExcCode bits are nonzero.
- `reset` asserted in the same cycle as req: reset wins, and all registers clear.

## Configuration
- `CP0_EPC_BYPASS_EN` defined:
  - `epc_out` = `din` when `we` and `addr`=14 in the current cycle, otherwise EPC.
  - This lets an `eret` in D/E use an EPC being written by an `mtc0` in M without a stall.
- Undefined: `epc_out` = EPC register only; the hazard unit must stall `eret` behind `mtc0` EPC.

## Structure
- Shared package/header holds:
  - register numbers: CP0_SR=12, CP0_CAUSE=13, CP0_EPC=14, CP0_PRID=15;
  - ExcCode constants: EXC_INT=0, EXC_ADEL=4, EXC_ADES=5, EXC_RI=10, EXC_OV=12;
  - SR/Cause field bit positions.
- Single module; no sub-module warranted.

## Test plan
- Reset, then `mfc0` 12/13/14/15 → 0, 0, 0, PRID; `req`=0.
- `mtc0` SR=32'h0000_0401, `hw_int`=6'b000001 → `req`=1 that cycle; next cycle EXL=1, ExcCode=0, EPC=`pc_m`, `req`=0.
- SR.IE=0, `exc_m`=6'b1_01100, `pc_m`=32'h3010, `bd_m`=1 → `req`=1; EPC=32'h300C, BD=1, ExcCode=12.
- With EXL=1, `exc_m`=6'b1_00100 → `req`=0 and Cause unchanged. Then `eret_m`=1 → EXL=0 next cycle.
- `we`=1, `addr`=14, `din`=32'h5000, with `exc_m` valid the same cycle → EPC=`pc_m`, not 32'h5000. With `CP0_EPC_BYPASS_EN` and no req, `epc_out`=32'h5000 in the same cycle.
- `hw_int`=6'b100000 with IM[15]=0 → `req`=0, IP[15]=1 readable via `mfc0` 13 on the next cycle.
